// File: rtl/io_bus_arbiter.sv
// rtl/io_bus_arbiter.sv - two-master round-robin arbiter and IO_Handler bus sequencer
// Optional feature macro: IO_ARB_LOCK_EN (adds lock0/lock1 for atomic back-to-back ownership)
module io_bus_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 1
) (
  input  logic        Clock,
  input  logic        Reset,
`ifdef IO_ARB_LOCK_EN
  input  logic        lock0,
  input  logic        lock1,
`endif
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic [3:0]  be0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  input  logic [3:0]  be1,
  output logic        grant0,
  output logic        grant1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] rdata,
  output logic        IO_Select,
  output logic        AS_L,
  output logic        WE_L,
  output logic [31:0] Address,
  output logic [31:0] IO_data_in,
  output logic [3:0]  byte_enable,
  input  logic [31:0] IO_data_out
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;
  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        last_served_q, last_served_d;
  logic        locked_q, locked_d;
  logic        we_q, we_d;
  logic        grant0_q, grant0_d, grant1_q, grant1_d;
  logic        done0_q, done0_d, done1_q, done1_d;
  logic [31:0] rdata_q, rdata_d;
  logic        io_select_q, io_select_d;
  logic        as_l_q, as_l_d;
  logic        we_l_q, we_l_d;
  logic [31:0] address_q, address_d;
  logic [31:0] io_data_in_q, io_data_in_d;
  logic [3:0]  byte_enable_q, byte_enable_d;
  logic        owner_lock;
  logic        take, win, win_we;

`ifdef IO_ARB_LOCK_EN
  assign owner_lock = owner_q ? lock1 : lock0;
`else
  assign owner_lock = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    owner_d       = owner_q;
    last_served_d = last_served_q;
    locked_d      = locked_q;
    we_d          = we_q;
    grant0_d      = grant0_q;
    grant1_d      = grant1_q;
    done0_d       = 1'b0;
    done1_d       = 1'b0;
    rdata_d       = rdata_q;
    io_select_d   = io_select_q;
    as_l_d        = as_l_q;
    we_l_d        = we_l_q;
    address_d     = address_q;
    io_data_in_d  = io_data_in_q;
    byte_enable_d = byte_enable_q;
    take          = 1'b0;
    win           = 1'b0;
    win_we        = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A locked owner that is still requesting keeps the bus ahead of round robin.
        if (locked_q && (owner_q ? req1 : req0)) begin
          take = 1'b1;
          win  = owner_q;
        end else if (req0 && req1) begin
          take = 1'b1;
          win  = ~last_served_q;
        end else if (req0 || req1) begin
          take = 1'b1;
          win  = req1 & ~req0;
        end
        if (take) begin
          win_we        = win ? we1 : we0;
          owner_d       = win;
          grant0_d      = ~win;
          grant1_d      = win;
          we_d          = win_we;
          address_d     = win ? addr1 : addr0;
          io_data_in_d  = win ? wdata1 : wdata0;
          byte_enable_d = win ? be1 : be0;
          io_select_d   = 1'b1;
          we_l_d        = ~win_we;
          locked_d      = 1'b0;
          state_d       = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = CNT_INIT;
        as_l_d  = 1'b0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          as_l_d      = 1'b1;
          io_select_d = 1'b0;
          we_l_d      = 1'b1;
          done0_d     = ~owner_q;
          done1_d     = owner_q;
          if (!we_q) rdata_d = IO_data_out;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        grant0_d = 1'b0;
        grant1_d = 1'b0;
        if (owner_lock) locked_d = 1'b1;
        else            last_served_d = owner_q;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      owner_q       <= 1'b0;
      last_served_q <= 1'b1;
      locked_q      <= 1'b0;
      we_q          <= 1'b0;
      grant0_q      <= 1'b0;
      grant1_q      <= 1'b0;
      done0_q       <= 1'b0;
      done1_q       <= 1'b0;
      rdata_q       <= 32'd0;
      io_select_q   <= 1'b0;
      as_l_q        <= 1'b1;
      we_l_q        <= 1'b1;
      address_q     <= 32'd0;
      io_data_in_q  <= 32'd0;
      byte_enable_q <= 4'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      owner_q       <= owner_d;
      last_served_q <= last_served_d;
      locked_q      <= locked_d;
      we_q          <= we_d;
      grant0_q      <= grant0_d;
      grant1_q      <= grant1_d;
      done0_q       <= done0_d;
      done1_q       <= done1_d;
      rdata_q       <= rdata_d;
      io_select_q   <= io_select_d;
      as_l_q        <= as_l_d;
      we_l_q        <= we_l_d;
      address_q     <= address_d;
      io_data_in_q  <= io_data_in_d;
      byte_enable_q <= byte_enable_d;
    end
  end

  assign grant0      = grant0_q;
  assign grant1      = grant1_q;
  assign done0       = done0_q;
  assign done1       = done1_q;
  assign rdata       = rdata_q;
  assign IO_Select   = io_select_q;
  assign AS_L        = as_l_q;
  assign WE_L        = we_l_q;
  assign Address     = address_q;
  assign IO_data_in  = io_data_in_q;
  assign byte_enable = byte_enable_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb/tb_io_bus_arbiter.sv - scoreboard bench for io_bus_arbiter (ACCESS_CYCLES 1 and 4 instances)
module tb_io_bus_arbiter;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic [3:0]  be0 = '0, be1 = '0;
  logic [31:0] IO_data_out = '0;
  logic        lock0 = 1'b0, lock1 = 1'b0;

  logic        grant0_a, grant1_a, done0_a, done1_a, io_select_a, as_l_a, we_l_a;
  logic [31:0] rdata_a, address_a, io_data_in_a;
  logic [3:0]  be_a;
  logic        grant0_b, grant1_b, done0_b, done1_b, io_select_b, as_l_b, we_l_b;
  logic [31:0] rdata_b, address_b, io_data_in_b;
  logic [3:0]  be_b;

  logic sel4 = 1'b0;
  wire        m_grant0    = sel4 ? grant0_b : grant0_a;
  wire        m_grant1    = sel4 ? grant1_b : grant1_a;
  wire        m_done0     = sel4 ? done0_b : done0_a;
  wire        m_done1     = sel4 ? done1_b : done1_a;
  wire        m_io_select = sel4 ? io_select_b : io_select_a;
  wire        m_as_l      = sel4 ? as_l_b : as_l_a;
  wire        m_we_l      = sel4 ? we_l_b : we_l_a;
  wire [31:0] m_rdata     = sel4 ? rdata_b : rdata_a;
  wire [31:0] m_address   = sel4 ? address_b : address_a;
  wire [31:0] m_io_din    = sel4 ? io_data_in_b : io_data_in_a;
  wire [3:0]  m_be        = sel4 ? be_b : be_a;

  always #5 Clock = ~Clock;

  io_bus_arbiter #(.ACCESS_CYCLES(1)) u_dut1 (
    .Clock(Clock), .Reset(Reset),
`ifdef IO_ARB_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .be0(be0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .be1(be1),
    .grant0(grant0_a), .grant1(grant1_a), .done0(done0_a), .done1(done1_a),
    .rdata(rdata_a), .IO_Select(io_select_a), .AS_L(as_l_a), .WE_L(we_l_a),
    .Address(address_a), .IO_data_in(io_data_in_a), .byte_enable(be_a),
    .IO_data_out(IO_data_out)
  );

  io_bus_arbiter #(.ACCESS_CYCLES(4)) u_dut4 (
    .Clock(Clock), .Reset(Reset),
`ifdef IO_ARB_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .be0(be0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .be1(be1),
    .grant0(grant0_b), .grant1(grant1_b), .done0(done0_b), .done1(done1_b),
    .rdata(rdata_b), .IO_Select(io_select_b), .AS_L(as_l_b), .WE_L(we_l_b),
    .Address(address_b), .IO_data_in(io_data_in_b), .byte_enable(be_b),
    .IO_data_out(IO_data_out)
  );

  typedef struct {
    int          who;
    int          done_cyc;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_rdata = '0;

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset;
    Reset = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    tick;
    Reset = 1'b0;
    model_rdata = '0;
    sb.delete();
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    tick;
    tick;
    checks++;
    if ({grant0_a, grant1_a, done0_a, done1_a, io_select_a, as_l_a, we_l_a} !== 7'b0000011) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000011", {grant0_a, grant1_a, done0_a, done1_a, io_select_a, as_l_a, we_l_a});
    end
    checks++;
    if ({rdata_a, address_a, io_data_in_a, be_a} !== 100'd0) begin
      errors++;
      $display("FAIL reset_data: rdata %h addr %h din %h be %h want all zero", rdata_a, address_a, io_data_in_a, be_a);
    end
    checks++;
    if ({grant0_b, grant1_b, done0_b, done1_b, io_select_b, as_l_b, we_l_b} !== 7'b0000011) begin
      errors++;
      $display("FAIL reset_ctrl4: got %b want 0000011", {grant0_b, grant1_b, done0_b, done1_b, io_select_b, as_l_b, we_l_b});
    end
    Reset = 1'b0;
    tick;
  endtask

  // One transaction from one requester; rd is driven on IO_data_out only in the last ACCESS cycle.
  task automatic do_txn(input string name, input int who, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, input logic [31:0] rd, input int acc);
    exp_t e, got;
    int   as_low;
    bit   seen;
    e.who = who;
    e.done_cyc = 2 + acc;
    e.rdata = we ? model_rdata : rd;
    model_rdata = e.rdata;
    sb.push_back(e);
    IO_data_out = ~rd;
    if (who == 0) begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; be0 = be; end
    else          begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; be1 = be; end
    as_low = 0;
    seen = 0;
    for (int c = 1; c <= 30 && !seen; c++) begin
      tick;
      if (c == 2) begin
        if (who == 0) begin addr0 = ~addr; wdata0 = ~wd; we0 = ~we; end
        else          begin addr1 = ~addr; wdata1 = ~wd; we1 = ~we; end
      end
      if (!m_as_l) as_low++;
      checks++;
      if ((m_grant0 && m_grant1) || (!m_as_l && !m_io_select) || (who == 0 ? m_grant1 : m_grant0)) begin
        errors++;
        $display("FAIL %s_invariant: cyc %0d g0 %b g1 %b as_l %b sel %b", name, c, m_grant0, m_grant1, m_as_l, m_io_select);
      end
      if (c <= 1 + acc) begin
        checks++;
        if ({m_io_select, m_we_l, m_as_l} !== {1'b1, ~we, (c == 1)}) begin
          errors++;
          $display("FAIL %s_bus_cyc%0d: sel/we_l/as_l got %b want %b", name, c, {m_io_select, m_we_l, m_as_l}, {1'b1, ~we, (c == 1)});
        end
        checks++;
        if ({m_address, m_io_din, m_be} !== {addr, wd, be}) begin
          errors++;
          $display("FAIL %s_fields_cyc%0d: got %h %h %h want %h %h %h", name, c, m_address, m_io_din, m_be, addr, wd, be);
        end
      end
      if (c == 1 + acc) IO_data_out = rd;
      if (m_done0 || m_done1) begin
        seen = 1;
        got = sb.pop_front();
        checks++;
        if ({m_done0, m_done1} !== (got.who == 0 ? 2'b10 : 2'b01) || c != got.done_cyc) begin
          errors++;
          $display("FAIL %s_done: done %b at cyc %0d want requester %0d at cyc %0d", name, {m_done0, m_done1}, c, got.who, got.done_cyc);
        end
        checks++;
        if (m_rdata !== got.rdata) begin
          errors++;
          $display("FAIL %s_rdata: got %h want %h", name, m_rdata, got.rdata);
        end
        checks++;
        if (as_low != acc) begin
          errors++;
          $display("FAIL %s_as_low: got %0d cycles want %0d", name, as_low, acc);
        end
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    if (!seen) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: no done within 30 cycles want done at cyc %0d", name, e.done_cyc);
      void'(sb.pop_front());
      req0 = 1'b0;
      req1 = 1'b0;
    end
    tick;
    checks++;
    if ({m_done0, m_done1, m_grant0, m_grant1, m_io_select, m_as_l} !== 6'b000001) begin
      errors++;
      $display("FAIL %s_idle: got %b want 000001", name, {m_done0, m_done1, m_grant0, m_grant1, m_io_select, m_as_l});
    end
  endtask

  // Both requesters held high; the done order is compared against the expected order queue.
  task automatic run_contention(input string name, input int n, input bit drop_lock);
    exp_t got;
    int   ndone;
    ndone = 0;
    we0 = 1'b0; we1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 0; c < 80 && ndone < n; c++) begin
      tick;
      if (drop_lock && ndone == 1 && lock0 && !m_done0 && !m_done1) lock0 = 1'b0;
      checks++;
      if ((m_grant0 && m_grant1) || (m_done0 && m_done1)) begin
        errors++;
        $display("FAIL %s_overlap: g %b%b d %b%b", name, m_grant0, m_grant1, m_done0, m_done1);
      end
      if (m_done0 || m_done1) begin
        got = sb.pop_front();
        ndone++;
        checks++;
        if ((m_done1 ? 1 : 0) != got.who) begin
          errors++;
          $display("FAIL %s_order%0d: served %0d want %0d", name, ndone, m_done1 ? 1 : 0, got.who);
        end
      end
    end
    checks++;
    if (ndone != n) begin
      errors++;
      $display("FAIL %s_timeout: got %0d dones want %0d", name, ndone, n);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    lock0 = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_single;
    sel4 = 1'b0;
    do_reset;
    do_txn("rd0", 0, 1'b0, 32'h0000_0000, 32'h0, 4'hF, 32'h0000_02A5, 1);
    do_txn("wr1", 1, 1'b1, 32'h0000_0004, 32'h0000_01FF, 4'h3, 32'hDEAD_BEEF, 1);
    do_txn("wr0", 0, 1'b1, 32'h0000_0010, 32'h1234_5678, 4'h1, 32'h0BAD_0BAD, 1);
    do_txn("rd1", 1, 1'b0, 32'h0000_0020, 32'h0, 4'hC, 32'h8765_4321, 1);
  endtask

  task automatic test_round_robin;
    exp_t e;
    sel4 = 1'b0;
    do_reset;
    for (int i = 0; i < 4; i++) begin
      e.who = i % 2; e.done_cyc = 0; e.rdata = '0;
      sb.push_back(e);
    end
    run_contention("rr", 4, 1'b0);
  endtask

  task automatic test_access4;
    sel4 = 1'b1;
    do_reset;
    do_txn("acc4", 0, 1'b0, 32'h0000_0104, 32'h0, 4'hF, 32'hCAFE_0104, 4);
    do_txn("acc4w", 1, 1'b1, 32'h0000_0108, 32'h55AA_55AA, 4'hF, 32'h1111_2222, 4);
    sel4 = 1'b0;
  endtask

  task automatic test_reset_mid;
    sel4 = 1'b0;
    do_reset;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40; IO_data_out = 32'h7777_7777;
    tick;
    tick;
    checks++;
    if (as_l_a !== 1'b0) begin
      errors++;
      $display("FAIL midrst_access: as_l got %b want 0", as_l_a);
    end
    Reset = 1'b1;
    req0 = 1'b0;
    tick;
    checks++;
    if ({as_l_a, grant0_a, done0_a, io_select_a, rdata_a} !== {4'b1000, 32'd0}) begin
      errors++;
      $display("FAIL midrst_abort: as_l %b g0 %b d0 %b sel %b rdata %h want 1 0 0 0 0", as_l_a, grant0_a, done0_a, io_select_a, rdata_a);
    end
    Reset = 1'b0;
    model_rdata = '0;
    tick;
    checks++;
    if (done0_a !== 1'b0) begin
      errors++;
      $display("FAIL midrst_nodone: done0 got %b want 0", done0_a);
    end
    do_txn("after_rst", 0, 1'b0, 32'h0000_0044, 32'h0, 4'hF, 32'h0000_9999, 1);
  endtask

`ifdef IO_ARB_LOCK_EN
  task automatic test_lock;
    exp_t e;
    sel4 = 1'b0;
    do_reset;
    lock0 = 1'b1;
    e.done_cyc = 0; e.rdata = '0;
    e.who = 0; sb.push_back(e);
    e.who = 0; sb.push_back(e);
    e.who = 1; sb.push_back(e);
    run_contention("lock", 3, 1'b1);
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_access4;
    test_reset_mid;
`ifdef IO_ARB_LOCK_EN
    test_lock;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
